wb_bus_arbiter: RTL and testbench
=================================

Name: wb_bus_arbiter

Overview:
- Shares the single Wishbone slave path between N bus masters: PET CPU, video fetch and SPI host. The slave path is SRAM, the register file and I/O, selected by address decoding downstream.
- Round-robin arbitration with optional fixed-priority masters; a tenure is held for the whole CYC.
- Includes a per-tenure watchdog so a hung slave cannot starve the other masters.
- Sits between the master-side bridges and the address decoder/slave mux.

Parameters:
- NUM_MASTERS, 3, number of requesters; index 0 = CPU, 1 = video, 2 = SPI host.
- PRIORITY_MASK, 3'b010, masters whose bit is set win over all unset masters; round-robin applies within each class.
- TIMEOUT_CYCLES, 64, cycles a granted STB may wait for ACK before the tenure is aborted; range 2..255.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- m_cyc_i  in  NUM_MASTERS  per-master CYC
- m_stb_i  in  NUM_MASTERS  per-master STB
- m_we_i  in  NUM_MASTERS  per-master WE
- m_addr_i  in  NUM_MASTERS*WB_ADDR_WIDTH  per-master address, master k at bits [k*W +: W]
- m_dat_i  in  NUM_MASTERS*8  per-master write data
- m_dat_o  out  8  read data broadcast to all masters, equal to s_dat_i
- m_ack_o  out  NUM_MASTERS  ACK routed to the owner only
- m_err_o  out  NUM_MASTERS  1-cycle ERR pulse to the owner on watchdog abort
- m_stall_o  out  NUM_MASTERS  high for every master that is not the current owner
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side strobes
- s_addr_o  out  WB_ADDR_WIDTH  muxed address
- s_dat_o  out  8  muxed write data
- s_dat_i  in  8  slave read data
- s_ack_i  in  1  slave ACK
- s_stall_i  in  1  slave STALL, passed through to the owner
- grant_o  out  NUM_MASTERS  one-hot current owner, all zero when idle (debug/visibility)

Behaviour:
- Reset (wb_rst_i high at a clock edge):
  - State = IDLE, grant_o = 0, last-owner pointer = NUM_MASTERS-1 (so master 0 is first in round-robin order), watchdog = 0.
  - All m_ack_o, m_err_o and s_* strobes = 0; m_stall_o = all ones.
  - Reset mid-tenure drops s_cyc_o in the same edge; no ACK is forwarded afterwards.
- States:
  - IDLE: no owner.
  - OWN: grant_o one-hot.
  - ABORT: single cycle, s_cyc_o = 0.
- IDLE -> OWN:
  - If any m_cyc_i is set, the winner is chosen combinationally and grant_o is registered at the next edge. Request at edge N gives grant visible at cycle N+1.
  - Winner: highest class (PRIORITY_MASK) containing a requester. Within that class, the first requester strictly after the last-owner pointer, modulo NUM_MASTERS.
  - The last-owner pointer updates to the winner.
- OWN:
  - s_cyc_o/s_stb_o/s_we_o/s_addr_o/s_dat_o are driven combinationally from the owner; s_cyc_o = m_cyc_i[owner].
  - m_ack_o[owner] = s_ack_i and m_stall_o[owner] = s_stall_i. Non-owner ACK/ERR are always 0.
- OWN -> IDLE: owner m_cyc_i low at an edge. This leaves exactly one idle cycle between tenures, including the case where the same master re-requests.
- Tenure length: the owner holds the bus for any number of transfers while CYC stays high. Preemption never occurs, even when a higher-priority master is requesting.
- Watchdog:
  - Counts cycles with owner STB high and s_ack_i low; clears on any ACK or when STB is low.
  - When the count reaches TIMEOUT_CYCLES: m_err_o[owner] pulses 1 cycle, state = ABORT (s_cyc_o = 0, grant_o = 0), then IDLE.
  - If ACK arrives in the same cycle the count hits the limit, ACK wins and no abort occurs.
- Simultaneous events: owner drops CYC while a new request is present → IDLE first; the new grant comes one edge later. Multiple requesters in IDLE are resolved purely by the rules above.
- Counter width: $clog2(TIMEOUT_CYCLES+1); saturates, never wraps.

Decomposition:
- common_pkg additions: WB_DATA_WIDTH = 8 and typedef arb_state_t {IDLE, OWN, ABORT}. WB_ADDR_WIDTH is already in the package.
- Sub-module rr_picker (combinational): inputs are the request vector, PRIORITY_MASK and the last-owner pointer; output is the one-hot winner.
- Watchdog counter and mux stay in the top module.

Test Plan:
- Single master: reset; CPU cyc/stb, addr = CPU-prefix 0x0100, slave ACK after 2 cycles.
  - Required: grant_o = 3'b001 at cycle 1, s_addr_o matches, m_ack_o = 3'b001 for one cycle, m_stall_o = 3'b110 during the tenure.
- Priority: CPU and video request at the same edge from IDLE.
  - Required: grant_o = 3'b010 (video) first. After video drops CYC: 1 idle cycle, then grant_o = 3'b001.
- Round-robin: CPU and SPI (same class) both request continuously, each tenure 1 transfer.
  - Required: grants alternate 001, 100, 001, 100 with one idle cycle between each.
- Watchdog: SPI owns and holds STB, slave never ACKs, TIMEOUT_CYCLES = 4.
  - Required: m_err_o = 3'b100 pulse on the 4th waiting cycle, then s_cyc_o = 0 for 1 cycle, then IDLE, and the pending CPU request is granted next.
- ACK at limit: ACK arrives exactly on the TIMEOUT_CYCLES-th cycle.
  - Required: m_ack_o pulses, no m_err_o, tenure continues.
- Reset mid-tenure: assert wb_rst_i while video owns with STB high.
  - Required: at the next edge grant_o = 0, s_cyc_o = 0, m_stall_o = 3'b111. After release, the first grant with all masters requesting goes to video (priority class); with only CPU and SPI requesting it goes to CPU.

Source files
------------

// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared Wishbone widths and bus arbiter state type
//
// Purpose: common constants and types imported by the Wishbone arbiter slice.
// Ports:   none (package).
package common_pkg;

  localparam int WB_ADDR_WIDTH = 16;
  localparam int WB_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_bus_arbiter_rr_picker.sv
// rtl/wb_bus_arbiter_rr_picker.sv - combinational two-class round-robin winner picker
//
// Purpose: selects one requester. Requesters whose priority bit is set win
//          over all others; within the winning class the first requester
//          strictly after the last owner (wrapping) is chosen.
// Ports:   i_req        request vector (one bit per master)
//          i_prio_mask  priority class membership
//          i_last       index of the previous owner
//          o_grant      one-hot winner, zero when nothing is requested
module rr_picker #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_prio_mask,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_grant
);

  logic [N-1:0]  w_hi;
  logic [N-1:0]  w_class;
  logic [IW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    w_hi    = i_req & i_prio_mask;
    // Fall back to the low class only when no priority master is asking.
    w_class = (|w_hi) ? w_hi : i_req;
    o_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    // k = N wraps back onto the last owner itself, so it is considered last.
    for (int k = 1; k <= N; k++) begin
      w_idx = IW'((int'(i_last) + k) % N);
      if (!w_found && w_class[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - Wishbone N-master arbiter with per-tenure watchdog
//
// Purpose: shares one Wishbone slave path between CPU (0), video (1) and SPI
//          host (2). A tenure lasts for the owner's whole CYC; a watchdog
//          aborts the tenure with an ERR pulse if the slave never ACKs.
// Ports:   wb_clk_i/wb_rst_i   clock, synchronous active-high reset
//          m_cyc_i/m_stb_i/m_we_i/m_addr_i/m_dat_i  master requests (packed per master)
//          m_dat_o             slave read data broadcast to all masters
//          m_ack_o/m_err_o     ACK / watchdog ERR routed to the owner only
//          m_stall_o           high for non-owners, slave STALL for the owner
//          s_cyc_o/s_stb_o/s_we_o/s_addr_o/s_dat_o  muxed slave-side request
//          s_dat_i/s_ack_i/s_stall_i               slave response
//          grant_o             one-hot current owner, zero when idle
module wb_bus_arbiter
  import common_pkg::*;
#(
  parameter int                     NUM_MASTERS    = 3,
  parameter logic [NUM_MASTERS-1:0] PRIORITY_MASK  = 3'b010,
  parameter int                     TIMEOUT_CYCLES = 64
) (
  input  logic                                   wb_clk_i,
  input  logic                                   wb_rst_i,
  input  logic [NUM_MASTERS-1:0]                 m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                 m_stb_i,
  input  logic [NUM_MASTERS-1:0]                 m_we_i,
  input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0]   m_addr_i,
  input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0]   m_dat_i,
  output logic [WB_DATA_WIDTH-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]                 m_ack_o,
  output logic [NUM_MASTERS-1:0]                 m_err_o,
  output logic [NUM_MASTERS-1:0]                 m_stall_o,
  output logic                                   s_cyc_o,
  output logic                                   s_stb_o,
  output logic                                   s_we_o,
  output logic [WB_ADDR_WIDTH-1:0]               s_addr_o,
  output logic [WB_DATA_WIDTH-1:0]               s_dat_o,
  input  logic [WB_DATA_WIDTH-1:0]               s_dat_i,
  input  logic                                   s_ack_i,
  input  logic                                   s_stall_i,
  output logic [NUM_MASTERS-1:0]                 grant_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t             r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [IW-1:0]          r_last;
  logic [CW-1:0]          r_wdog;

  logic [NUM_MASTERS-1:0] w_win;
  logic [IW-1:0]          w_win_idx;
  logic                   w_own_cyc;
  logic                   w_own_stb;
  logic                   w_timeout;

  rr_picker #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_picker (
    .i_req       (m_cyc_i),
    .i_prio_mask (PRIORITY_MASK),
    .i_last      (r_last),
    .o_grant     (w_win)
  );

  always_comb begin
    w_win_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (w_win[k]) w_win_idx = IW'(k);
    end
  end

  // r_grant is zero outside OWN, so the mux idles at zero without a state check.
  always_comb begin
    s_addr_o = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (r_grant[k]) begin
        s_addr_o = m_addr_i[k*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
        s_dat_o  = m_dat_i[k*WB_DATA_WIDTH +: WB_DATA_WIDTH];
        s_we_o   = m_we_i[k];
      end
    end
  end

  assign w_own_cyc = |(m_cyc_i & r_grant);
  assign w_own_stb = |(m_stb_i & r_grant);

  // Fires on the TIMEOUT_CYCLES-th waiting cycle; an ACK in that cycle wins.
  assign w_timeout = w_own_cyc & w_own_stb & ~s_ack_i &
                     (r_wdog == CW'(TIMEOUT_CYCLES - 1));

  assign s_cyc_o   = w_own_cyc;
  assign s_stb_o   = w_own_cyc & w_own_stb;
  assign m_dat_o   = s_dat_i;
  assign m_ack_o   = r_grant & {NUM_MASTERS{s_ack_i}};
  assign m_err_o   = r_grant & {NUM_MASTERS{w_timeout}};
  assign m_stall_o = ~r_grant | (r_grant & {NUM_MASTERS{s_stall_i}});
  assign grant_o   = r_grant;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= IW'(NUM_MASTERS - 1);
      r_wdog  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wdog <= '0;
          if (|m_cyc_i) begin
            r_state <= OWN;
            r_grant <= w_win;
            r_last  <= w_win_idx;
          end
        end
        OWN: begin
          if (w_timeout) begin
            r_state <= ABORT;
            r_grant <= '0;
            r_wdog  <= '0;
          end else if (!w_own_cyc) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_wdog  <= '0;
          end else if (w_own_stb && !s_ack_i) begin
            if (r_wdog != CW'(TIMEOUT_CYCLES)) r_wdog <= r_wdog + 1'b1;
          end else begin
            r_wdog <= '0;
          end
        end
        ABORT: begin
          r_state <= IDLE;
          r_grant <= '0;
          r_wdog  <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
          r_wdog  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - scoreboard bench for wb_bus_arbiter
module tb_wb_bus_arbiter;
  import common_pkg::*;

  localparam int N  = 3;
  localparam int AW = WB_ADDR_WIDTH;
  localparam int DW = WB_DATA_WIDTH;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i = 1'b1;
  logic [N-1:0]      m_cyc_i  = '0;
  logic [N-1:0]      m_stb_i  = '0;
  logic [N-1:0]      m_we_i   = 3'b100;
  logic [N*AW-1:0]   m_addr_i = {16'h3300, 16'h2200, 16'h0100};
  logic [N*DW-1:0]   m_dat_i  = {8'hC2, 8'hB1, 8'hA0};
  logic [DW-1:0]     m_dat_o;
  logic [N-1:0]      m_ack_o;
  logic [N-1:0]      m_err_o;
  logic [N-1:0]      m_stall_o;
  logic              s_cyc_o;
  logic              s_stb_o;
  logic              s_we_o;
  logic [AW-1:0]     s_addr_o;
  logic [DW-1:0]     s_dat_o;
  logic [DW-1:0]     s_dat_i  = '0;
  logic              s_ack_i  = 1'b0;
  logic              s_stall_i = 1'b0;
  logic [N-1:0]      grant_o;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_bus_arbiter #(
    .NUM_MASTERS    (3),
    .PRIORITY_MASK  (3'b010),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .m_cyc_i   (m_cyc_i),
    .m_stb_i   (m_stb_i),
    .m_we_i    (m_we_i),
    .m_addr_i  (m_addr_i),
    .m_dat_i   (m_dat_i),
    .m_dat_o   (m_dat_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .m_stall_o (m_stall_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_addr_o  (s_addr_o),
    .s_dat_o   (s_dat_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i),
    .s_stall_i (s_stall_i),
    .grant_o   (grant_o)
  );

  typedef struct packed {
    logic [2:0]    grant;
    logic [2:0]    ack;
    logic [2:0]    err;
    logic [2:0]    stall;
    logic          scyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] sdat;
    logic [DW-1:0] mdat;
  } obs_t;

  obs_t  q_exp[$];
  string q_name[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    row_cnt = 0;

  function automatic logic [AW-1:0] addr_of(input logic [2:0] g);
    case (g)
      3'b001:  return 16'h0100;
      3'b010:  return 16'h2200;
      3'b100:  return 16'h3300;
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] dat_of(input logic [2:0] g);
    case (g)
      3'b001:  return 8'hA0;
      3'b010:  return 8'hB1;
      3'b100:  return 8'hC2;
      default: return '0;
    endcase
  endfunction

  // Drive one cycle of inputs, queue the outputs expected in that cycle, advance.
  task automatic row(input string nm, input logic rst,
                     input logic [2:0] cyc, input logic [2:0] stb,
                     input logic sack, input logic sst,
                     input logic [2:0] g, input logic [2:0] a,
                     input logic [2:0] e, input logic [2:0] st, input logic sc);
    obs_t x;
    wb_rst_i  = rst;
    m_cyc_i   = cyc;
    m_stb_i   = stb;
    s_ack_i   = sack;
    s_stall_i = sst;
    s_dat_i   = 8'(row_cnt * 37 + 5);
    x.grant = g;
    x.ack   = a;
    x.err   = e;
    x.stall = st;
    x.scyc  = sc;
    x.addr  = addr_of(g);
    x.sdat  = dat_of(g);
    x.mdat  = s_dat_i;
    q_exp.push_back(x);
    q_name.push_back(nm);
    row_cnt++;
    @(posedge wb_clk_i);
    #1;
  endtask

  // Monitor: compares DUT outputs each cycle an expectation is pending.
  initial begin
    obs_t e;
    obs_t a;
    string nm;
    forever begin
      @(negedge wb_clk_i);
      if (q_exp.size() > 0) begin
        e  = q_exp.pop_front();
        nm = q_name.pop_front();
        a.grant = grant_o;
        a.ack   = m_ack_o;
        a.err   = m_err_o;
        a.stall = m_stall_o;
        a.scyc  = s_cyc_o;
        a.addr  = s_addr_o;
        a.sdat  = s_dat_o;
        a.mdat  = m_dat_o;
        if (e.grant == 3'b000) begin
          a.addr = '0;
          a.sdat = '0;
        end
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL %s: got grant=%b ack=%b err=%b stall=%b scyc=%b addr=%h sdat=%h mdat=%h; want grant=%b ack=%b err=%b stall=%b scyc=%b addr=%h sdat=%h mdat=%h",
                   nm, a.grant, a.ack, a.err, a.stall, a.scyc, a.addr, a.sdat, a.mdat,
                   e.grant, e.ack, e.err, e.stall, e.scyc, e.addr, e.sdat, e.mdat);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got time %0t want < 100000", $time);
    $fatal(1);
  end

  initial begin
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    #1;
    //   name          rst cyc     stb     ack stl grant   ack     err     stall   scyc
    row("rst_state",   1, 3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0);

    // single master, ACK two cycles after grant
    row("t1_req",      0, 3'b001, 3'b001, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0);
    row("t1_grant",    0, 3'b001, 3'b001, 0, 0, 3'b001, 3'b000, 3'b000, 3'b110, 1);
    row("t1_stall",    0, 3'b001, 3'b001, 0, 1, 3'b001, 3'b000, 3'b000, 3'b111, 1);
    row("t1_ack",      0, 3'b001, 3'b001, 1, 0, 3'b001, 3'b001, 3'b000, 3'b110, 1);
    row("t1_drop",     0, 3'b000, 3'b000, 0, 0, 3'b001, 3'b000, 3'b000, 3'b110, 0);
    row("t1_idle",     0, 3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0);

    // priority: video beats CPU, CPU follows after one idle cycle
    row("t2_req",      0, 3'b011, 3'b011, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0);
    row("t2_video",    0, 3'b011, 3'b011, 1, 0, 3'b010, 3'b010, 3'b000, 3'b101, 1);
    row("t2_vdrop",    0, 3'b001, 3'b001, 0, 0, 3'b010, 3'b000, 3'b000, 3'b101, 0);
    row("t2_gap",      0, 3'b001, 3'b001, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0);
    row("t2_cpu",      0, 3'b001, 3'b001, 1, 0, 3'b001, 3'b001, 3'b000, 3'b110, 1);
    row("t2_cdrop",    0, 3'b000, 3'b000, 0, 0, 3'b001, 3'b000, 3'b000, 3'b110, 0);
    row("t2_idle",     0, 3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0);

    // round-robin between CPU and SPI from a fresh pointer
    row("t3_rst",      1, 3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0);
    for (int i = 0; i < 2; i++) begin
      row("t3_gap_c",  0, 3'b101, 3'b101, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0);
      row("t3_cpu",    0, 3'b101, 3'b101, 1, 0, 3'b001, 3'b001, 3'b000, 3'b110, 1);
      row("t3_cdrop",  0, 3'b100, 3'b100, 0, 0, 3'b001, 3'b000, 3'b000, 3'b110, 0);
      row("t3_gap_s",  0, 3'b101, 3'b101, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0);
      row("t3_spi",    0, 3'b101, 3'b101, 1, 0, 3'b100, 3'b100, 3'b000, 3'b011, 1);
      row("t3_sdrop",  0, 3'b001, 3'b001, 0, 0, 3'b100, 3'b000, 3'b000, 3'b011, 0);
    end
    row("t3_last",     0, 3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0);

    // watchdog: SPI waits 4 cycles without ACK, CPU pending
    row("t4_req",      0, 3'b100, 3'b100, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0);
    row("t4_wait1",    0, 3'b101, 3'b100, 0, 0, 3'b100, 3'b000, 3'b000, 3'b011, 1);
    row("t4_wait2",    0, 3'b101, 3'b100, 0, 0, 3'b100, 3'b000, 3'b000, 3'b011, 1);
    row("t4_wait3",    0, 3'b101, 3'b100, 0, 0, 3'b100, 3'b000, 3'b000, 3'b011, 1);
    row("t4_err",      0, 3'b101, 3'b100, 0, 0, 3'b100, 3'b000, 3'b100, 3'b011, 1);
    row("t4_abort",    0, 3'b101, 3'b100, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0);
    row("t4_idle",     0, 3'b101, 3'b100, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0);
    row("t4_cpu",      0, 3'b101, 3'b100, 0, 0, 3'b001, 3'b000, 3'b000, 3'b110, 1);
    row("t4_drop",     0, 3'b000, 3'b000, 0, 0, 3'b001, 3'b000, 3'b000, 3'b110, 0);
    row("t4_end",      0, 3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0);

    // ACK on the limit cycle keeps the tenure alive
    row("t5_req",      0, 3'b001, 3'b001, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0);
    row("t5_wait1",    0, 3'b001, 3'b001, 0, 0, 3'b001, 3'b000, 3'b000, 3'b110, 1);
    row("t5_wait2",    0, 3'b001, 3'b001, 0, 0, 3'b001, 3'b000, 3'b000, 3'b110, 1);
    row("t5_wait3",    0, 3'b001, 3'b001, 0, 0, 3'b001, 3'b000, 3'b000, 3'b110, 1);
    row("t5_ack_lim",  0, 3'b001, 3'b001, 1, 0, 3'b001, 3'b001, 3'b000, 3'b110, 1);
    row("t5_cont",     0, 3'b001, 3'b001, 0, 0, 3'b001, 3'b000, 3'b000, 3'b110, 1);
    row("t5_drop",     0, 3'b000, 3'b000, 0, 0, 3'b001, 3'b000, 3'b000, 3'b110, 0);
    row("t5_end",      0, 3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0);

    // reset while video owns with STB high
    row("t6_req",      0, 3'b010, 3'b010, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0);
    row("t6_own",      0, 3'b010, 3'b010, 0, 0, 3'b010, 3'b000, 3'b000, 3'b101, 1);
    row("t6_rst",      1, 3'b010, 3'b010, 0, 0, 3'b010, 3'b000, 3'b000, 3'b101, 1);
    row("t6_after",    0, 3'b111, 3'b111, 1, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0);
    row("t6_video",    0, 3'b101, 3'b101, 0, 0, 3'b010, 3'b000, 3'b000, 3'b101, 0);
    row("t6_rst2",     1, 3'b101, 3'b101, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0);
    row("t6_req2",     0, 3'b101, 3'b101, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0);
    row("t6_cpu",      0, 3'b101, 3'b101, 1, 0, 3'b001, 3'b001, 3'b000, 3'b110, 1);
    row("t6_drop",     0, 3'b000, 3'b000, 0, 0, 3'b001, 3'b000, 3'b000, 3'b110, 0);
    row("t6_end",      0, 3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111, 0);

    @(negedge wb_clk_i);
    #1;
    n_cmp++;
    if (q_exp.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, want 0", q_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
